// File: rtl/pkg_tx_frame.sv
// Buffers one package of 16-bit words and re-sends it as a framed byte stream:
// two sync bytes, the package bytes MSB-first, then an 8-bit additive checksum.
module pkg_tx_frame #(
    parameter int         DEPTH = 16,
    parameter logic [7:0] SYNC0 = 8'hEB,
    parameter logic [7:0] SYNC1 = 8'h90
) (
    input  logic        i_clk_sys,
    input  logic        i_rst_n,
    input  logic [15:0] i_pkg_d,
    input  logic        i_pkg_vld,
    output logic        o_pkg_done,
    output logic [7:0]  o_tx_d,
    output logic        o_tx_vld,
    input  logic        i_tx_rdy,
    output logic        o_pkg_err,
    output logic        o_busy
);

    localparam int         AW    = $clog2(DEPTH);
    localparam logic [8:0] MAX_N = 9'(DEPTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LOAD, ST_DROP, ST_SYNC0, ST_SYNC1, ST_DATA, ST_CSUM, ST_DONE
    } state_t;

    state_t          r_state;
    logic [7:0]      r_n;
    logic [7:0]      r_cnt;
    logic [7:0]      r_csum;
    logic [AW-1:0]   r_rptr;
    logic            r_hi_shown;
    logic [7:0]      r_tx_d;
    logic            r_tx_vld;
    logic            r_pkg_done;
    logic            r_pkg_err;
    logic [15:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_addr;
    logic            w_oversize;
    logic [7:0]      w_word_sum;
    logic [AW-1:0]   w_rptr_inc;
    logic [15:0]     w_rd_word;
    logic [15:0]     w_next_word;
    logic            w_in_rx;

    assign w_accept    = r_tx_vld & i_tx_rdy;
    assign w_in_rx     = (r_state == ST_IDLE) || (r_state == ST_LOAD) || (r_state == ST_DROP);
    assign w_wr_en     = i_pkg_vld && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    assign w_wr_addr   = (r_state == ST_IDLE) ? '0 : r_cnt[AW-1:0];
    assign w_oversize  = {1'b0, i_pkg_d[7:0]} > MAX_N;
    assign w_word_sum  = i_pkg_d[15:8] + i_pkg_d[7:0];
    assign w_rptr_inc  = r_rptr + AW'(1);
    assign w_rd_word   = r_mem[r_rptr];
    assign w_next_word = r_mem[w_rptr_inc];

    always_ff @(posedge i_clk_sys) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= i_pkg_d;
        end
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_n        <= '0;
            r_cnt      <= '0;
            r_csum     <= '0;
            r_rptr     <= '0;
            r_hi_shown <= 1'b0;
            r_tx_d     <= '0;
            r_tx_vld   <= 1'b0;
            r_pkg_done <= 1'b0;
            r_pkg_err  <= 1'b0;
        end else begin
            r_pkg_done <= 1'b0;
            // Words arriving while a frame is on the wire are dropped and flagged.
            r_pkg_err  <= i_pkg_vld && !w_in_rx;
            case (r_state)
                ST_IDLE: begin
                    if (i_pkg_vld) begin
                        r_n    <= i_pkg_d[7:0];
                        r_cnt  <= 8'd1;
                        r_rptr <= '0;
                        r_csum <= w_word_sum;
                        if (w_oversize) begin
                            r_state <= ST_DROP;
                        end else if (i_pkg_d[7:0] == 8'd0) begin
                            r_tx_d   <= SYNC0;
                            r_tx_vld <= 1'b1;
                            r_state  <= ST_SYNC0;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_pkg_vld) begin
                        r_csum <= r_csum + w_word_sum;
                        if (r_cnt == r_n) begin
                            r_tx_d   <= SYNC0;
                            r_tx_vld <= 1'b1;
                            r_state  <= ST_SYNC0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (i_pkg_vld) begin
                        if (r_cnt == r_n) begin
                            r_pkg_err  <= 1'b1;
                            r_pkg_done <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                ST_SYNC0: begin
                    if (w_accept) begin
                        r_tx_d  <= SYNC1;
                        r_state <= ST_SYNC1;
                    end
                end
                ST_SYNC1: begin
                    if (w_accept) begin
                        r_tx_d     <= w_rd_word[15:8];
                        r_hi_shown <= 1'b1;
                        r_state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        if (r_hi_shown) begin
                            r_tx_d     <= w_rd_word[7:0];
                            r_hi_shown <= 1'b0;
                        end else if (r_rptr == r_n[AW-1:0]) begin
                            r_tx_d  <= r_csum;
                            r_state <= ST_CSUM;
                        end else begin
                            r_tx_d     <= w_next_word[15:8];
                            r_rptr     <= w_rptr_inc;
                            r_hi_shown <= 1'b1;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_accept) begin
                        r_tx_vld   <= 1'b0;
                        r_pkg_done <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_tx_d     = r_tx_d;
    assign o_tx_vld   = r_tx_vld;
    assign o_pkg_done = r_pkg_done;
    assign o_pkg_err  = r_pkg_err;
    assign o_busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pkg_tx_frame.sv
// Self-checking bench for pkg_tx_frame: directed table, corner sequences and
// random packages compared against a byte-level frame model.
module tb_pkg_tx_frame;

    localparam int DEPTH = 16;

    typedef logic [15:0] wordQ_t[$];
    typedef logic [7:0]  byteQ_t[$];

    typedef struct {
        int              n;
        logic [2:0][15:0] w;
        int              rdyMode;
        bit              stray;
        logic [7:0]      expCsum;
        int              expLen;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic [15:0] pkgD;
    logic        pkgVld;
    logic        txRdy;
    logic        pkgDone;
    logic [7:0]  txD;
    logic        txVld;
    logic        pkgErr;
    logic        busy;

    int nVectors    = 0;
    int nMiscompares = 0;

    pkg_tx_frame #(.DEPTH(DEPTH), .SYNC0(8'hEB), .SYNC1(8'h90)) dut (
        .i_clk_sys (clk),
        .i_rst_n   (rstN),
        .i_pkg_d   (pkgD),
        .i_pkg_vld (pkgVld),
        .o_pkg_done(pkgDone),
        .o_tx_d    (txD),
        .o_tx_vld  (txVld),
        .i_tx_rdy  (txRdy),
        .o_pkg_err (pkgErr),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Frame as seen on the link: sync bytes, every package byte MSB-first, byte sum.
    function automatic byteQ_t modelFrame(input wordQ_t words);
        byteQ_t q;
        int     sum;
        q = {};
        if (int'(words[0][7:0]) > DEPTH - 1) return q;
        sum = 0;
        q.push_back(8'hEB);
        q.push_back(8'h90);
        foreach (words[k]) begin
            q.push_back(words[k][15:8]);
            q.push_back(words[k][7:0]);
            sum = sum + words[k][15:8] + words[k][7:0];
        end
        q.push_back(8'(sum % 256));
        return q;
    endfunction

    task automatic applyStimulus(input wordQ_t words, input int rdyMode, input bit gaps,
                                 input bit stray, input int resetAfter,
                                 input logic [7:0] expCsum, input int expLen);
        byteQ_t     expQ;
        byteQ_t     got;
        logic [3:0] pat;
        logic [7:0] holdD;
        logic [7:0] b;
        bit         holdValid, strayPending, strayDone, oversize, timedOut;
        int         wi, cyc, lastWordCyc, firstVldCyc, lastAccCyc, doneCyc;
        int         errCnt, doneCnt, errDoneTogether, vldCycles;
        expQ = modelFrame(words);
        got = {};
        pat = 4'b1001;
        holdD = '0;
        holdValid = 0; strayPending = 0; strayDone = 0; timedOut = 0;
        oversize = int'(words[0][7:0]) > DEPTH - 1;
        wi = 0; cyc = 0; lastWordCyc = -1; firstVldCyc = -1; lastAccCyc = -1; doneCyc = -1;
        errCnt = 0; doneCnt = 0; errDoneTogether = 0; vldCycles = 0;
        forever begin
            @(posedge clk);
            #1;
            pkgVld = 1'b0;
            if (wi < words.size() && (!gaps || $urandom_range(2) != 0)) begin
                pkgD   = words[wi];
                pkgVld = 1'b1;
                if (wi == words.size() - 1) lastWordCyc = cyc;
                wi++;
            end else if (strayPending) begin
                pkgD         = 16'($urandom);
                pkgVld       = 1'b1;
                strayPending = 0;
                strayDone    = 1;
            end
            txRdy = (rdyMode == 0) ? 1'b1 : (rdyMode == 1) ? pat[cyc % 4] : 1'($urandom_range(1));
            @(negedge clk);
            if (cyc == 0) checkOutput("busyIdle", busy, 0);
            if (holdValid) checkOutput("txHold", {txVld, txD}, {1'b1, holdD});
            holdValid = txVld && !txRdy;
            holdD     = txD;
            if (txVld) begin
                vldCycles++;
                if (firstVldCyc < 0) firstVldCyc = cyc;
            end
            if (txVld && txRdy) begin
                got.push_back(txD);
                lastAccCyc = cyc;
                if (stray && !strayDone && got.size() == 1) strayPending = 1;
            end
            if (pkgErr) errCnt++;
            if (pkgDone) begin
                doneCnt++;
                doneCyc = cyc;
                if (pkgErr) errDoneTogether = 1;
            end
            if (resetAfter >= 0 && got.size() == resetAfter) begin
                @(posedge clk);
                #1;
                rstN = 1'b0;
                #1;
                checkOutput("txVldOnReset", txVld, 0);
                checkOutput("busyOnReset", busy, 0);
                for (int k = 0; k < resetAfter; k++) checkOutput("prefixByte", got[k], expQ[k]);
                repeat (3) begin
                    @(negedge clk);
                    if (pkgDone) doneCnt++;
                end
                rstN = 1'b1;
                checkOutput("doneAfterReset", doneCnt, 0);
                return;
            end
            cyc++;
            if (doneCnt > 0) break;
            if (cyc > 3000) begin
                timedOut = 1;
                break;
            end
        end
        checkOutput("frameTimeout", timedOut, 0);
        if (oversize) begin
            checkOutput("dropNoTx", vldCycles, 0);
            checkOutput("dropDoneCnt", doneCnt, 1);
            checkOutput("dropErrCnt", errCnt, 1);
            checkOutput("dropErrWithDone", errDoneTogether, 1);
            checkOutput("dropDoneTiming", doneCyc, lastWordCyc + 1);
        end else begin
            checkOutput("frameLen", got.size(), expLen);
            for (int k = 0; k < expQ.size(); k++) begin
                b = (k < got.size()) ? got[k] : 8'hxx;
                checkOutput($sformatf("byte%0d", k), b, expQ[k]);
            end
            checkOutput("csum", (got.size() > 0) ? got[got.size() - 1] : 8'hxx, expCsum);
            checkOutput("firstVldTiming", firstVldCyc, lastWordCyc + 1);
            checkOutput("doneTiming", doneCyc, lastAccCyc + 1);
            checkOutput("doneCnt", doneCnt, 1);
            checkOutput("errCnt", errCnt, stray ? 1 : 0);
            if (rdyMode == 0) checkOutput("vldCycles", vldCycles, expLen);
        end
    endtask

    initial begin
        vec_t   vecs[4];
        wordQ_t q;
        byteQ_t e;
        int     n;

        vecs[0] = '{n: 2, w: {16'h00FF, 16'hA0B0, 16'h0102}, rdyMode: 0, stray: 0, expCsum: 8'h52, expLen: 9};
        vecs[1] = '{n: 0, w: {16'h0000, 16'h0000, 16'hAB00}, rdyMode: 0, stray: 0, expCsum: 8'hAB, expLen: 5};
        vecs[2] = '{n: 2, w: {16'h00FF, 16'hA0B0, 16'h0102}, rdyMode: 1, stray: 0, expCsum: 8'h52, expLen: 9};
        vecs[3] = '{n: 2, w: {16'h00FF, 16'hA0B0, 16'h0102}, rdyMode: 0, stray: 1, expCsum: 8'h52, expLen: 9};

        rstN = 1'b0; pkgVld = 1'b0; pkgD = '0; txRdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstTxVld", txVld, 0);
        checkOutput("rstTxD", txD, 0);
        checkOutput("rstDone", pkgDone, 0);
        checkOutput("rstErr", pkgErr, 0);
        checkOutput("rstBusy", busy, 0);
        rstN = 1'b1;

        foreach (vecs[i]) begin
            q = {};
            for (int k = 0; k <= vecs[i].n; k++) q.push_back(vecs[i].w[k]);
            applyStimulus(q, vecs[i].rdyMode, 0, vecs[i].stray, -1, vecs[i].expCsum, vecs[i].expLen);
        end

        q = {16'h0020};
        for (int k = 0; k < 32; k++) q.push_back(16'(k * 16'h0101));
        applyStimulus(q, 0, 0, 0, -1, 8'h00, 0);
        q = {16'h0102, 16'hA0B0, 16'h00FF};
        applyStimulus(q, 0, 0, 0, -1, 8'h52, 9);

        applyStimulus(q, 0, 0, 0, 3, 8'h52, 9);
        applyStimulus(q, 0, 0, 0, -1, 8'h52, 9);

        for (int r = 0; r < 20; r++) begin
            n = ($urandom_range(5) == 0) ? $urandom_range(16, 40) : $urandom_range(0, 15);
            q = {};
            q.push_back({8'($urandom), 8'(n)});
            for (int k = 0; k < n; k++) q.push_back(16'($urandom));
            e = modelFrame(q);
            applyStimulus(q, 2, 1, 0, -1, (e.size() > 0) ? e[e.size() - 1] : 8'h00, e.size());
        end

        @(negedge clk);
        checkOutput("busyEnd", busy, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
